// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: shared opcode encodings, op classes and decode helpers for the issue stage
package alu_issue_ctrl_pkg;
  localparam int NREG    = 32;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 8;
  localparam int LAT_MAX = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP32   = 7'h3b;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_FENCE  = 7'h0f;
  localparam logic [6:0] FUNCT7_MD  = 7'b0000001;

  // {funct3, opcode}; R-type values double as MUL/DIV forms when funct7 selects muldiv
  typedef enum logic [9:0] {
    OP_FENCE = 10'h00f,
    OP_ADDI  = 10'h013,
    OP_ADD   = 10'h033,
    OP_LUI   = 10'h037,
    OP_ADDW  = 10'h03b,
    OP_BEQ   = 10'h063,
    OP_LW    = 10'h103,
    OP_SW    = 10'h123,
    OP_XOR   = 10'h233,
    OP_SRLW  = 10'h2bb,
    OP_OR    = 10'h333
  } opcode_e;

  typedef enum logic [1:0] {CLS_SINGLE, CLS_MUL, CLS_DIV} op_class_e;

  typedef enum logic [0:0] {S_IDLE, S_BUSY} state_e;

  function automatic op_class_e op_class(input logic [9:0] opcode, input logic [6:0] funct7);
    logic md;
    md = funct7 == FUNCT7_MD && (opcode[6:0] == OPC_OP || opcode[6:0] == OPC_OP32);
    return !md ? CLS_SINGLE : (opcode[9] ? CLS_DIV : CLS_MUL);
  endfunction

  function automatic logic writes_rd(input logic [9:0] opcode, input logic [4:0] rd);
    return rd != 5'd0 && opcode[6:0] != OPC_STORE && opcode[6:0] != OPC_BRANCH && opcode[6:0] != OPC_FENCE;
  endfunction
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: decode, alu issue and writeback signals between the pipeline and the issue controller
interface alu_issue_ctrl_if;
  logic       dec_valid;
  logic       dec_ready;
  logic [9:0] dec_opcode;
  logic [6:0] dec_funct7;
  logic [4:0] dec_rs1;
  logic [4:0] dec_rs2;
  logic       dec_uses_rs2;
  logic [4:0] dec_rd;
  logic       alu_issue;
  logic [9:0] alu_opcode;
  logic [4:0] alu_rd;
  logic       alu_busy;
  logic       alu_done;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       flush;

  modport master (
    output dec_valid, dec_opcode, dec_funct7, dec_rs1, dec_rs2, dec_uses_rs2, dec_rd, wb_valid, wb_rd, flush,
    input  dec_ready, alu_issue, alu_opcode, alu_rd, alu_busy, alu_done
  );

  modport slave (
    input  dec_valid, dec_opcode, dec_funct7, dec_rs1, dec_rs2, dec_uses_rs2, dec_rd, wb_valid, wb_rd, flush,
    output dec_ready, alu_issue, alu_opcode, alu_rd, alu_busy, alu_done
  );
endinterface

// File: rtl/alu_issue_ctrl_reg_scoreboard.sv
// reg_scoreboard: per-register pending-write bits with writeback bypass on both read ports
module reg_scoreboard
  import alu_issue_ctrl_pkg::*;
#(
  parameter int N  = NREG,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_all,
  input  logic          set_en,
  input  logic [IW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [IW-1:0] clr_idx,
  input  logic [IW-1:0] rd_a,
  input  logic [IW-1:0] rd_b,
  output logic          busy_a,
  output logic          busy_b
);
  logic [N-1:0] busy_q, busy_d;

  // set is applied after clear so a same-cycle issue to the written-back register keeps it pending
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
    busy_d[0] = 1'b0;
    if (clear_all) busy_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else busy_q <= busy_d;
  end

  assign busy_a = busy_q[rd_a] && rd_a != '0 && !(clr_en && clr_idx == rd_a);
  assign busy_b = busy_q[rd_b] && rd_b != '0 && !(clr_en && clr_idx == rd_b);
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decode-to-alu issue stage with RAW scoreboard and fixed-latency MUL/DIV sequencing
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
(
  input logic clk,
  input logic reset,
  alu_issue_ctrl_if.slave bus
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             issue_q, issue_d;
  logic [9:0]       opcode_q, opcode_d;
  logic [4:0]       rd_q, rd_d;
  logic             busy_rs1, busy_rs2, hazard, ready, hs, set_en;
  op_class_e        cls;

  reg_scoreboard u_sb (
    .clk       (clk),
    .reset     (reset),
    .clear_all (bus.flush),
    .set_en    (set_en),
    .set_idx   (bus.dec_rd),
    .clr_en    (bus.wb_valid),
    .clr_idx   (bus.wb_rd),
    .rd_a      (bus.dec_rs1),
    .rd_b      (bus.dec_rs2),
    .busy_a    (busy_rs1),
    .busy_b    (busy_rs2)
  );

  always_comb begin
    hazard   = busy_rs1 || (bus.dec_uses_rs2 && busy_rs2);
    ready    = state_q == S_IDLE && !hazard && !bus.flush;
    hs       = bus.dec_valid && ready;
    cls      = op_class(bus.dec_opcode, bus.dec_funct7);
    set_en   = hs && writes_rd(bus.dec_opcode, bus.dec_rd);
    state_d  = state_q;
    cnt_d    = cnt_q;
    issue_d  = hs;
    opcode_d = hs ? bus.dec_opcode : opcode_q;
    rd_d     = hs ? bus.dec_rd : rd_q;
    if (bus.flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (state_q == S_BUSY) begin
      state_d = cnt_q == '0 ? S_IDLE : S_BUSY;
      cnt_d   = cnt_q == '0 ? '0 : cnt_q - CNT_W'(1);
    end else if (hs && cls != CLS_SINGLE) begin
      state_d = S_BUSY;
      cnt_d   = cls == CLS_DIV ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      issue_q  <= 1'b0;
      opcode_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      issue_q  <= issue_d;
      opcode_q <= opcode_d;
      rd_q     <= rd_d;
    end
  end

  assign bus.dec_ready  = ready;
  assign bus.alu_issue  = issue_q;
  assign bus.alu_opcode = opcode_q;
  assign bus.alu_rd     = rd_q;
  assign bus.alu_busy   = state_q == S_BUSY;
  assign bus.alu_done   = state_q == S_BUSY && cnt_q == '0;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed scenarios plus randomized traffic against a cycle-level reference model
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_issue_ctrl_if bus();
  alu_issue_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;

  bit         mbusy [32];
  int         mleft;
  bit         missue;
  logic [9:0] mopc;
  logic [4:0] mrd;
  logic [9:0] pool [11] = '{OP_ADDI, OP_ADD, OP_XOR, OP_OR, OP_ADDW, OP_SRLW, OP_SW, OP_BEQ, OP_FENCE, OP_LW, OP_LUI};

  function automatic bit m_pending(input logic [4:0] r);
    return r != 0 && mbusy[r] && !(bus.wb_valid && bus.wb_rd == r);
  endfunction

  function automatic bit m_ready();
    return mleft == 0 && !bus.flush && !(m_pending(bus.dec_rs1) || (bus.dec_uses_rs2 && m_pending(bus.dec_rs2)));
  endfunction

  function automatic logic [31:0] m_vec();
    logic [31:0] v = '0;
    foreach (mbusy[i]) v[i] = mbusy[i];
    return v;
  endfunction

  task automatic tick();
    bit hs = bus.dec_valid && m_ready();
    bit md = bus.dec_funct7 == 7'd1 && (bus.dec_opcode[6:0] == 7'h33 || bus.dec_opcode[6:0] == 7'h3b);
    bit wr = bus.dec_rd != 0 && !(bus.dec_opcode[6:0] inside {7'h23, 7'h63, 7'h0f});
    if (reset || bus.flush) begin
      foreach (mbusy[i]) mbusy[i] = 1'b0;
      mleft  = 0;
      missue = 1'b0;
      if (reset) begin
        mopc = '0;
        mrd  = '0;
      end
    end else begin
      if (bus.wb_valid) mbusy[bus.wb_rd] = 1'b0;
      if (hs && wr) mbusy[bus.dec_rd] = 1'b1;
      missue = hs;
      if (hs) begin
        mopc = bus.dec_opcode;
        mrd  = bus.dec_rd;
      end
      if (mleft > 0) mleft--;
      else if (hs && md) mleft = bus.dec_opcode[9] ? DIV_LAT : MUL_LAT;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [9:0] opc, input logic [6:0] f7, input logic [4:0] rs1,
                       input logic [4:0] rs2, input bit u2, input logic [4:0] rd);
    bus.dec_valid    = v;
    bus.dec_opcode   = opc;
    bus.dec_funct7   = f7;
    bus.dec_rs1      = rs1;
    bus.dec_rs2      = rs2;
    bus.dec_uses_rs2 = u2;
    bus.dec_rd       = rd;
    bus.wb_valid     = 1'b0;
    bus.wb_rd        = '0;
    bus.flush        = 1'b0;
  endtask

  task automatic do_reset();
    drive(0, OP_ADDI, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    tick();
    checks++; if (bus.alu_issue !== 1'b0) begin errors++; $display("FAIL reset_issue: got %0b want 0", bus.alu_issue); end
    checks++; if (bus.alu_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", bus.alu_busy); end
    checks++; if (bus.alu_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", bus.alu_done); end
    checks++; if (bus.alu_opcode !== 10'd0 || bus.alu_rd !== 5'd0) begin errors++; $display("FAIL reset_fields: got opc=%h rd=%0d want 0/0", bus.alu_opcode, bus.alu_rd); end
    checks++; if (dut.u_sb.busy_q !== 32'd0) begin errors++; $display("FAIL reset_sb: got %h want 0", dut.u_sb.busy_q); end
    checks++; if (bus.dec_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", bus.dec_ready); end
    reset = 1'b0;
  endtask

  task automatic test_single_issue();
    do_reset();
    drive(1, OP_ADDI, 0, 0, 0, 0, 5);
    #1;
    checks++; if (bus.dec_ready !== 1'b1) begin errors++; $display("FAIL addi_ready: got %0b want 1", bus.dec_ready); end
    tick();
    drive(0, OP_ADDI, 0, 0, 0, 0, 0);
    checks++; if (bus.alu_issue !== 1'b1 || bus.alu_rd !== 5'd5 || bus.alu_opcode !== OP_ADDI) begin errors++; $display("FAIL addi_issue: got issue=%0b rd=%0d opc=%h want 1/5/013", bus.alu_issue, bus.alu_rd, bus.alu_opcode); end
    checks++; if (dut.u_sb.busy_q !== 32'h20) begin errors++; $display("FAIL addi_sb: got %h want 00000020", dut.u_sb.busy_q); end
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    tick();
    bus.wb_valid = 1'b0;
    checks++; if (bus.alu_issue !== 1'b0 || dut.u_sb.busy_q !== 32'd0) begin errors++; $display("FAIL addi_wb: got issue=%0b sb=%h want 0/0", bus.alu_issue, dut.u_sb.busy_q); end
  endtask

  task automatic test_raw_bypass();
    do_reset();
    drive(1, OP_ADDI, 0, 0, 0, 0, 5);
    tick();
    drive(1, OP_ADD, 0, 5, 1, 1, 6);
    #1;
    checks++; if (bus.dec_ready !== 1'b0) begin errors++; $display("FAIL raw_stall: got %0b want 0", bus.dec_ready); end
    tick();
    checks++; if (bus.alu_issue !== 1'b0) begin errors++; $display("FAIL raw_noissue: got %0b want 0", bus.alu_issue); end
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    #1;
    checks++; if (bus.dec_ready !== 1'b1) begin errors++; $display("FAIL raw_bypass: got %0b want 1", bus.dec_ready); end
    tick();
    drive(0, OP_ADDI, 0, 0, 0, 0, 0);
    checks++; if (bus.alu_issue !== 1'b1 || bus.alu_rd !== 5'd6 || dut.u_sb.busy_q !== 32'h40) begin errors++; $display("FAIL raw_issue: got issue=%0b rd=%0d sb=%h want 1/6/00000040", bus.alu_issue, bus.alu_rd, dut.u_sb.busy_q); end
  endtask

  task automatic test_div();
    do_reset();
    drive(1, OP_XOR, 7'd1, 1, 2, 1, 7);
    tick();
    drive(0, OP_ADDI, 0, 0, 0, 0, 0);
    for (int i = 1; i <= DIV_LAT; i++) begin
      #1;
      checks++; if (bus.alu_busy !== 1'b1 || bus.alu_done !== (i == DIV_LAT) || bus.dec_ready !== 1'b0 || bus.alu_issue !== (i == 1)) begin
        errors++; $display("FAIL div_cycle%0d: got busy=%0b done=%0b ready=%0b issue=%0b want 1/%0b/0/%0b", i, bus.alu_busy, bus.alu_done, bus.dec_ready, bus.alu_issue, i == DIV_LAT, i == 1);
      end
      tick();
    end
    checks++; if (bus.alu_busy !== 1'b0 || bus.alu_done !== 1'b0 || bus.dec_ready !== 1'b1) begin errors++; $display("FAIL div_end: got busy=%0b done=%0b ready=%0b want 0/0/1", bus.alu_busy, bus.alu_done, bus.dec_ready); end
  endtask

  task automatic test_store_branch();
    do_reset();
    drive(1, OP_ADDI, 0, 0, 0, 0, 5);
    tick();
    drive(1, OP_SW, 0, 1, 5, 1, 5);
    #1;
    checks++; if (bus.dec_ready !== 1'b0) begin errors++; $display("FAIL store_stall: got %0b want 0", bus.dec_ready); end
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    tick();
    drive(1, OP_BEQ, 0, 1, 2, 1, 9);
    checks++; if (bus.alu_issue !== 1'b1 || dut.u_sb.busy_q !== 32'd0) begin errors++; $display("FAIL store_issue: got issue=%0b sb=%h want 1/0", bus.alu_issue, dut.u_sb.busy_q); end
    tick();
    drive(1, OP_ADDI, 0, 0, 0, 0, 0);
    checks++; if (bus.alu_issue !== 1'b1 || dut.u_sb.busy_q !== 32'd0) begin errors++; $display("FAIL branch_rd9: got issue=%0b sb=%h want 1/0", bus.alu_issue, dut.u_sb.busy_q); end
    tick();
    drive(0, OP_ADDI, 0, 0, 0, 0, 0);
    checks++; if (bus.alu_rd !== 5'd0 || dut.u_sb.busy_q !== 32'd0) begin errors++; $display("FAIL x0_busy: got rd=%0d sb=%h want 0/0", bus.alu_rd, dut.u_sb.busy_q); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, OP_XOR, 7'd1, 1, 2, 1, 7);
    tick();
    drive(0, OP_ADDI, 0, 0, 0, 0, 0);
    repeat (4) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    checks++; if (bus.alu_busy !== 1'b0 || bus.alu_done !== 1'b0 || dut.u_sb.busy_q !== 32'd0 || bus.dec_ready !== 1'b1) begin
      errors++; $display("FAIL flush_busy: got busy=%0b done=%0b sb=%h ready=%0b want 0/0/0/1", bus.alu_busy, bus.alu_done, dut.u_sb.busy_q, bus.dec_ready);
    end
    tick();
    checks++; if (bus.alu_done !== 1'b0 || bus.alu_busy !== 1'b0) begin errors++; $display("FAIL flush_after: got done=%0b busy=%0b want 0/0", bus.alu_done, bus.alu_busy); end
    drive(1, OP_ADDI, 0, 0, 0, 0, 3);
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.dec_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %0b want 0", bus.dec_ready); end
    tick();
    drive(0, OP_ADDI, 0, 0, 0, 0, 0);
    checks++; if (bus.alu_issue !== 1'b0 || dut.u_sb.busy_q !== 32'd0) begin errors++; $display("FAIL flush_suppress: got issue=%0b sb=%h want 0/0", bus.alu_issue, dut.u_sb.busy_q); end
  endtask

  task automatic test_same_cycle_and_reset();
    do_reset();
    drive(1, OP_ADDI, 0, 0, 0, 0, 4);
    tick();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd4;
    tick();
    drive(0, OP_ADDI, 0, 0, 0, 0, 0);
    checks++; if (bus.alu_issue !== 1'b1 || dut.u_sb.busy_q !== 32'h10) begin errors++; $display("FAIL set_wins: got issue=%0b sb=%h want 1/00000010", bus.alu_issue, dut.u_sb.busy_q); end
    drive(1, OP_ADD, 7'd1, 1, 2, 1, 8);
    tick();
    drive(0, OP_ADDI, 0, 0, 0, 0, 0);
    checks++; if (bus.alu_busy !== 1'b1) begin errors++; $display("FAIL mul_busy: got %0b want 1", bus.alu_busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (bus.alu_issue !== 1'b0 || bus.alu_busy !== 1'b0 || bus.alu_done !== 1'b0 || bus.alu_opcode !== 10'd0 || bus.alu_rd !== 5'd0 || dut.u_sb.busy_q !== 32'd0) begin
      errors++; $display("FAIL reset_midbusy: got issue=%0b busy=%0b done=%0b opc=%h rd=%0d sb=%h want all 0", bus.alu_issue, bus.alu_busy, bus.alu_done, bus.alu_opcode, bus.alu_rd, dut.u_sb.busy_q);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      drive($urandom_range(0, 3) != 0, pool[$urandom_range(0, 10)], ($urandom_range(0, 2) == 0) ? 7'd1 : 7'd0,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
      bus.wb_valid = $urandom_range(0, 2) == 0;
      bus.wb_rd    = 5'($urandom_range(0, 7));
      bus.flush    = $urandom_range(0, 39) == 0;
      #1;
      checks++; if (bus.dec_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready c=%0d: got %0b want %0b", c, bus.dec_ready, m_ready()); end
      tick();
      checks++; if (bus.alu_issue !== missue || bus.alu_opcode !== mopc || bus.alu_rd !== mrd) begin
        errors++; $display("FAIL rnd_issue c=%0d: got %0b/%h/%0d want %0b/%h/%0d", c, bus.alu_issue, bus.alu_opcode, bus.alu_rd, missue, mopc, mrd);
      end
      checks++; if (bus.alu_busy !== (mleft > 0) || bus.alu_done !== (mleft == 1)) begin
        errors++; $display("FAIL rnd_busy c=%0d: got busy=%0b done=%0b want %0b/%0b", c, bus.alu_busy, bus.alu_done, mleft > 0, mleft == 1);
      end
      checks++; if (dut.u_sb.busy_q !== m_vec()) begin errors++; $display("FAIL rnd_sb c=%0d: got %h want %h", c, dut.u_sb.busy_q, m_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_single_issue();
    test_raw_bypass();
    test_div();
    test_store_branch();
    test_flush();
    test_same_cycle_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
